// File: rtl/croc_soc_ctrl_lite_if.sv
// rtl/croc_soc_ctrl_lite_if.sv - OBI-style subordinate bus bundle for the SoC control block
interface croc_soc_ctrl_lite_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/croc_soc_ctrl_lite.sv
// rtl/croc_soc_ctrl_lite.sv - croc SoC control registers (boot address, fetch enable, status) and GPIO
module croc_soc_ctrl_lite #(
  parameter int unsigned GpioCount       = 32,
  parameter logic [31:0] BootAddrDefault = 32'h1000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  croc_soc_ctrl_lite_if.slave  bus,
  input  logic                 fetch_en_i,
  output logic                 fetch_en_o,
  output logic [31:0]          boot_addr_o,
  output logic                 status_o,
  input  logic [GpioCount-1:0] gpio_i,
  output logic [GpioCount-1:0] gpio_o,
  output logic [GpioCount-1:0] gpio_out_en_o
);

  typedef enum logic [2:0] {
    REG_BOOTADDR    = 3'd0,
    REG_FETCHEN     = 3'd1,
    REG_CORESTATUS  = 3'd2,
    REG_RESERVED    = 3'd3,
    REG_GPIO_DIR    = 3'd4,
    REG_GPIO_OUT    = 3'd5,
    REG_GPIO_IN     = 3'd6,
    REG_GPIO_TOGGLE = 3'd7
  } reg_idx_e;

  reg_idx_e             reg_idx;
  logic                 wr_en;
  logic                 rd_en;
  logic [31:0]          be_mask;
  logic [31:0]          read_val;
  logic [31:0]          core_status_wr;
  logic [GpioCount-1:0] gpio_wmask;
  logic [GpioCount-1:0] gpio_wdata;
  logic                 unused_addr;

  logic [31:0]          boot_addr_q;
  logic                 fetch_en_q;
  logic [31:0]          core_status_q;
  logic                 status_q;
  logic [GpioCount-1:0] gpio_dir_q;
  logic [GpioCount-1:0] gpio_out_q;
  logic [GpioCount-1:0] gpio_sync1_q;
  logic [GpioCount-1:0] gpio_in_q;
  logic                 rvalid_q;
  logic                 err_q;
  logic [31:0]          rdata_q;

  // Only the word index is decoded; the rest of the address aliases.
  assign unused_addr = ^{bus.addr[31:5], bus.addr[1:0]};
  assign reg_idx     = reg_idx_e'(bus.addr[4:2]);
  assign wr_en       = bus.req & bus.we;
  assign rd_en       = bus.req & ~bus.we;

  always_comb begin
    be_mask = '0;
    for (int i = 0; i < 4; i++) begin
      be_mask[8*i +: 8] = {8{bus.be[i]}};
    end
  end

  assign gpio_wmask     = be_mask[GpioCount-1:0];
  assign gpio_wdata     = bus.wdata[GpioCount-1:0];
  assign core_status_wr = (core_status_q & ~be_mask) | (bus.wdata & be_mask);

  always_comb begin
    read_val = '0;
    case (reg_idx)
      REG_BOOTADDR:   read_val = boot_addr_q;
      REG_FETCHEN:    read_val = {31'b0, fetch_en_q};
      REG_CORESTATUS: read_val = core_status_q;
      REG_GPIO_DIR:   read_val = 32'(gpio_dir_q);
      REG_GPIO_OUT:   read_val = 32'(gpio_out_q);
      REG_GPIO_IN:    read_val = 32'(gpio_in_q);
      default:        read_val = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_addr_q   <= BootAddrDefault;
      fetch_en_q    <= 1'b0;
      core_status_q <= '0;
      status_q      <= 1'b0;
      gpio_dir_q    <= '0;
      gpio_out_q    <= '0;
      gpio_sync1_q  <= '0;
      gpio_in_q     <= '0;
      rvalid_q      <= 1'b0;
      err_q         <= 1'b0;
      rdata_q       <= '0;
    end else begin
      gpio_sync1_q <= gpio_i;
      gpio_in_q    <= gpio_sync1_q;
      // Reads sample the pre-edge register value; write responses carry zero data.
      rvalid_q     <= bus.req;
      rdata_q      <= rd_en ? read_val : '0;
      err_q        <= bus.req && (reg_idx == REG_RESERVED);
      if (wr_en) begin
        case (reg_idx)
          REG_BOOTADDR:    boot_addr_q <= (boot_addr_q & ~be_mask) | (bus.wdata & be_mask);
          REG_FETCHEN:     if (bus.be[0]) fetch_en_q <= bus.wdata[0];
          REG_CORESTATUS: begin
            core_status_q <= core_status_wr;
            status_q      <= |core_status_wr;
          end
          REG_GPIO_DIR:    gpio_dir_q <= (gpio_dir_q & ~gpio_wmask) | (gpio_wdata & gpio_wmask);
          REG_GPIO_OUT:    gpio_out_q <= (gpio_out_q & ~gpio_wmask) | (gpio_wdata & gpio_wmask);
          REG_GPIO_TOGGLE: gpio_out_q <= gpio_out_q ^ (gpio_wdata & gpio_wmask);
          default: ;
        endcase
      end
    end
  end

  assign bus.gnt       = bus.req;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign fetch_en_o    = fetch_en_i | fetch_en_q;
  assign boot_addr_o   = boot_addr_q;
  assign status_o      = status_q;
  assign gpio_o        = gpio_out_q;
  assign gpio_out_en_o = gpio_dir_q;

endmodule

// File: tb/tb_croc_soc_ctrl_lite.sv
// tb/tb_croc_soc_ctrl_lite.sv - self-checking bench for croc_soc_ctrl_lite
module tb_croc_soc_ctrl_lite;
  localparam logic [31:0] BOOT_DEF = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en_i;
  logic        fetch_en_o;
  logic [31:0] boot_addr;
  logic        status;
  logic [31:0] gpio_i;
  logic [31:0] gpio_o;
  logic [31:0] gpio_en;
  logic [31:0] ext;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  croc_soc_ctrl_lite_if bus ();

  assign gpio_i = {ext[31:8], gpio_o[3:0] & gpio_en[3:0], ext[3:0]};

  croc_soc_ctrl_lite #(
    .GpioCount       (32),
    .BootAddrDefault (BOOT_DEF)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus           (bus.slave),
    .fetch_en_i    (fetch_en_i),
    .fetch_en_o    (fetch_en_o),
    .boot_addr_o   (boot_addr),
    .status_o      (status),
    .gpio_i        (gpio_i),
    .gpio_o        (gpio_o),
    .gpio_out_en_o (gpio_en)
  );

  // Reference model: register contents plus a history of sampled pin values.
  logic [31:0] m_boot, m_core, m_dir, m_out;
  logic        m_fetch;
  logic [31:0] pin_q[$];
  logic        exp_rvalid, exp_err;
  logic [31:0] exp_rdata;

  typedef struct {
    logic        fen;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        fen_o;
    logic        status;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot     = BOOT_DEF;
    m_fetch    = 1'b0;
    m_core     = '0;
    m_dir      = '0;
    m_out      = '0;
    pin_q      = {32'h0, 32'h0};
    exp_rvalid = 1'b0;
    exp_err    = 1'b0;
    exp_rdata  = '0;
  endtask

  task automatic model_edge(input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] mask;
    logic [31:0] pins;
    int          idx;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    idx  = int'(addr[4:2]);
    pins = {ext[31:8], m_out[3:0] & m_dir[3:0], ext[3:0]};
    exp_rvalid = req;
    exp_err    = req && (idx == 3);
    exp_rdata  = '0;
    if (req && !we) begin
      case (idx)
        0: exp_rdata = m_boot;
        1: exp_rdata = {31'b0, m_fetch};
        2: exp_rdata = m_core;
        4: exp_rdata = m_dir;
        5: exp_rdata = m_out;
        6: exp_rdata = pin_q[0];
        default: exp_rdata = '0;
      endcase
    end
    if (req && we) begin
      case (idx)
        0: m_boot = (m_boot & ~mask) | (wdata & mask);
        1: if (be[0]) m_fetch = wdata[0];
        2: m_core = (m_core & ~mask) | (wdata & mask);
        4: m_dir  = (m_dir & ~mask) | (wdata & mask);
        5: m_out  = (m_out & ~mask) | (wdata & mask);
        7: m_out  = m_out ^ (wdata & mask);
        default: ;
      endcase
    end
    pin_q.push_back(pins);
    void'(pin_q.pop_front());
  endtask

  task automatic check_outputs();
    chk("rvalid", bus.rvalid, exp_rvalid);
    chk("rdata", bus.rdata, exp_rdata);
    chk("err", bus.err, exp_err);
    chk("fetch_en_o", fetch_en_o, fetch_en_i | m_fetch);
    chk("boot_addr_o", boot_addr, m_boot);
    chk("status_o", status, m_core != 0);
    chk("gpio_o", gpio_o, m_out);
    chk("gpio_out_en_o", gpio_en, m_dir);
  endtask

  task automatic bus_cycle(input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req   = req;
    bus.we    = we;
    bus.be    = be;
    bus.addr  = addr;
    bus.wdata = wdata;
    #1;
    chk("gnt", bus.gnt, req);
    @(posedge clk);
    model_edge(req, we, be, addr, wdata);
    #1;
    check_outputs();
  endtask

  task automatic add_vec(input logic fen, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic err,
                         input logic fen_o, input logic st);
    vec_t v;
    v.fen = fen; v.we = we; v.be = be; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.err = err; v.fen_o = fen_o; v.status = st;
    vecs.push_back(v);
  endtask

  initial begin
    //       fen we be    addr          wdata         rdata         err fen_o st
    add_vec(0, 0, 4'hF, 32'h0000_0000, 32'h0,        32'h1000_0000, 0, 0, 0);
    add_vec(0, 0, 4'hF, 32'h0000_0008, 32'h0,        32'h0,         0, 0, 0);
    add_vec(0, 1, 4'hF, 32'h0000_0008, 32'h1234_5678, 32'h0,        0, 0, 1);
    add_vec(0, 0, 4'hF, 32'h0000_0008, 32'h0,        32'h1234_5678, 0, 0, 1);
    add_vec(0, 1, 4'hF, 32'h0000_0008, 32'h0,        32'h0,         0, 0, 0);
    add_vec(0, 1, 4'h2, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0,        0, 0, 1);
    add_vec(0, 0, 4'hF, 32'h0000_0008, 32'h0,        32'h0000_FF00, 0, 0, 1);
    add_vec(0, 1, 4'hF, 32'h0000_0004, 32'h1,        32'h0,         0, 1, 1);
    add_vec(0, 1, 4'hF, 32'h0000_0004, 32'h0,        32'h0,         0, 0, 1);
    add_vec(1, 0, 4'hF, 32'h0000_0004, 32'h0,        32'h0,         0, 1, 1);
    add_vec(1, 1, 4'hF, 32'h0000_0004, 32'h0,        32'h0,         0, 1, 1);
    add_vec(0, 1, 4'hF, 32'h0000_0004, 32'hFFFF_FFFF, 32'h0,        0, 1, 1);
    add_vec(0, 0, 4'hF, 32'h0000_0004, 32'h0,        32'h1,         0, 1, 1);
    add_vec(0, 1, 4'h1, 32'h0000_0004, 32'h0,        32'h0,         0, 0, 1);
    add_vec(0, 1, 4'h0, 32'h0000_0008, 32'h0,        32'h0,         0, 0, 1);
    add_vec(0, 0, 4'hF, 32'h0000_000C, 32'h0,        32'h0,         1, 0, 1);
    add_vec(0, 1, 4'hF, 32'h0000_0018, 32'hFFFF_FFFF, 32'h0,        0, 0, 1);
    add_vec(0, 0, 4'hF, 32'h0000_001C, 32'h0,        32'h0,         0, 0, 1);
    add_vec(0, 0, 4'hF, 32'hABCD_E003, 32'h0,        32'h1000_0000, 0, 0, 1);

    ext        = '0;
    fetch_en_i = 1'b0;
    bus.req    = 1'b1;
    bus.we     = 1'b0;
    bus.be     = 4'h0;
    bus.addr   = '0;
    bus.wdata  = '0;
    rst_n      = 1'b0;
    model_reset();
    #12;
    chk("reset gnt", bus.gnt, 1'b1);
    chk("reset rvalid", bus.rvalid, 1'b0);
    chk("reset boot_addr", boot_addr, BOOT_DEF);
    chk("reset status", status, 1'b0);
    chk("reset gpio_o", gpio_o, 32'h0);
    chk("reset fetch_en_o", fetch_en_o, 1'b0);
    bus.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      fetch_en_i = vecs[i].fen;
      bus_cycle(1'b1, vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      chk($sformatf("vec%0d rdata", i), bus.rdata, vecs[i].rdata);
      chk($sformatf("vec%0d err", i), bus.err, vecs[i].err);
      chk($sformatf("vec%0d fetch_en_o", i), fetch_en_o, vecs[i].fen_o);
      chk($sformatf("vec%0d status", i), status, vecs[i].status);
    end
    fetch_en_i = 1'b0;

    // GPIO loopback through the synchronizer, then toggle.
    bus_cycle(1, 1, 4'hF, 32'h10, 32'hF);
    bus_cycle(1, 1, 4'hF, 32'h14, 32'hA);
    repeat (3) bus_cycle(0, 0, 4'h0, 32'h0, 32'h0);
    bus_cycle(1, 0, 4'hF, 32'h18, 32'h0);
    chk("loopback gpio_in", bus.rdata, 32'h0000_00A0);
    bus_cycle(1, 1, 4'hF, 32'h1C, 32'h3);
    chk("toggle gpio_o", gpio_o[3:0], 4'h9);
    bus_cycle(1, 0, 4'hF, 32'h14, 32'h0);
    chk("toggle readback", bus.rdata, 32'h9);

    // Back-to-back requests.
    bus_cycle(1, 1, 4'hF, 32'h00, 32'h2000_0000);
    chk("b2b0 rdata", bus.rdata, 32'h0);
    bus_cycle(1, 0, 4'hF, 32'h00, 32'h0);
    chk("b2b1 rdata", bus.rdata, 32'h2000_0000);
    bus_cycle(1, 0, 4'hF, 32'h0C, 32'h0);
    chk("b2b2 err", bus.err, 1'b1);
    bus_cycle(1, 0, 4'hF, 32'h1C, 32'h0);
    chk("b2b3 rvalid", bus.rvalid, 1'b1);
    chk("b2b3 err", bus.err, 1'b0);

    // Reset while a read response is pending.
    bus_cycle(1, 1, 4'hF, 32'h08, 32'h5);
    bus_cycle(1, 0, 4'hF, 32'h00, 32'h0);
    chk("pre-reset rvalid", bus.rvalid, 1'b1);
    bus.req    = 1'b0;
    fetch_en_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("mid-reset rvalid", bus.rvalid, 1'b0);
    chk("mid-reset rdata", bus.rdata, 32'h0);
    chk("mid-reset boot_addr", boot_addr, BOOT_DEF);
    chk("mid-reset status", status, 1'b0);
    chk("mid-reset gpio_o", gpio_o, 32'h0);
    chk("mid-reset gpio_en", gpio_en, 32'h0);
    chk("mid-reset fetch_en_o", fetch_en_o, 1'b1);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n      = 1'b1;
    fetch_en_i = 1'b0;
    bus_cycle(1, 0, 4'hF, 32'h00, 32'h0);
    chk("post-reset boot read", bus.rdata, BOOT_DEF);
    bus_cycle(1, 0, 4'hF, 32'h08, 32'h0);
    chk("post-reset status read", bus.rdata, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) ext = $urandom;
      fetch_en_i = 1'($urandom_range(0, 1));
      bus_cycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
